// File: rtl/exec_branch_unit.sv
// Execute datapath: 32-bit ALU, PC adders, branch resolution,
// plus the one stored-carry register used by carry branches.
module exec_branch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ALUop,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [5:0]  shamt,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [1:0]  flag,
  input  logic        branch,
  input  logic        branchType,
  input  logic        brNotEq,
  input  logic        carry_we,
  output logic [31:0] out,
  output logic        carryflag,
  output logic        zflag,
  output logic        signflag,
  output logic        carry_q,
  output logic [31:0] pc_plus_4,
  output logic [31:0] label_address,
  output logic [31:0] next_pc,
  output logic        brType
);

  logic [32:0] sum;
  logic [5:0]  amt;
  logic [31:0] shl;
  logic [31:0] shr;
  logic [31:0] sra;
  logic        cond;

  // Immediate-form shifts use shamt, variable forms use y[5:0]
  always_comb begin
    unique case (ALUop)
      4'b0110, 4'b0111, 4'b1001: amt = y[5:0];
      default:                   amt = shamt;
    endcase
  end

  always_comb begin
    shl = '0;
    shr = '0;
    sra = {32{x[31]}};
    if (!amt[5]) begin
      shl = x << amt[4:0];
      shr = x >> amt[4:0];
      sra = 32'($signed(x) >>> amt[4:0]);
    end
  end

  always_comb begin
    sum = '0;
    unique case (ALUop)
      4'b0000: sum = {1'b0, x} + {1'b0, y};
      4'b0001: sum = {1'b0, ~y} + 33'd1;
      4'b1011: sum = {1'b0, x} + {1'b0, ~y} + 33'd1;
      default: sum = '0;
    endcase
  end

  always_comb begin
    out = '0;
    carryflag = 1'b0;
    unique case (ALUop)
      4'b0000, 4'b0001, 4'b1011: begin
        out = sum[31:0];
        carryflag = sum[32];
      end
      4'b0010: out = x & y;
      4'b0011: out = x ^ y;
      4'b0100, 4'b0110: out = shl;
      4'b0101, 4'b0111: out = shr;
      4'b1000, 4'b1001: out = sra;
      4'b1010: out = x;
      default: out = '0;
    endcase
  end

  assign zflag    = (out == 32'd0);
  assign signflag = out[31];

  assign pc_plus_4     = pc + 32'd4;
  assign label_address = pc_plus_4 + {imm[29:0], 2'b00};

  // Carry branches see only the registered carry of an earlier op
  always_comb begin
    unique case (flag)
      2'b00:   cond = zflag;
      2'b01:   cond = signflag;
      2'b10:   cond = carry_q;
      default: cond = 1'b1;
    endcase
  end

  assign brType  = branch | (branchType & (cond ^ brNotEq));
  assign next_pc = brType ? label_address : pc_plus_4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_q <= 1'b0;
    end else if (carry_we) begin
      carry_q <= carryflag;
    end
  end

endmodule

// File: tb/tb_exec_branch_unit.sv
// Scoreboard bench for exec_branch_unit: expectations queued at
// drive time, popped and compared once outputs have settled.
module tb_exec_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ALUop;
  logic [31:0] x, y, pc, imm;
  logic [5:0]  shamt;
  logic [1:0]  flag;
  logic        branch, branchType, brNotEq, carry_we;
  logic [31:0] out, pc_plus_4, label_address, next_pc;
  logic        carryflag, zflag, signflag, carry_q, brType;

  exec_branch_unit dut (
    .clk(clk), .reset(reset), .ALUop(ALUop), .x(x), .y(y),
    .shamt(shamt), .pc(pc), .imm(imm), .flag(flag),
    .branch(branch), .branchType(branchType), .brNotEq(brNotEq),
    .carry_we(carry_we), .out(out), .carryflag(carryflag),
    .zflag(zflag), .signflag(signflag), .carry_q(carry_q),
    .pc_plus_4(pc_plus_4), .label_address(label_address),
    .next_pc(next_pc), .brType(brType)
  );

  always #5 clk = ~clk;

  typedef enum int {
    O_OUT, O_CF, O_ZF, O_SF, O_CQ, O_PC4, O_LBL, O_NPC, O_BR
  } sel_t;

  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%08h want=%08h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] observe(input sel_t s);
    case (s)
      O_OUT:   return out;
      O_CF:    return {31'd0, carryflag};
      O_ZF:    return {31'd0, zflag};
      O_SF:    return {31'd0, signflag};
      O_CQ:    return {31'd0, carry_q};
      O_PC4:   return pc_plus_4;
      O_LBL:   return label_address;
      O_NPC:   return next_pc;
      default: return {31'd0, brType};
    endcase
  endfunction

  task automatic expect_v(input string tag, input sel_t s,
                          input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [5:0] sh);
    ALUop = op;
    x = a;
    y = b;
    shamt = sh;
  endtask

  task automatic shift_case(input string tag, input logic [3:0] op,
                            input logic [31:0] b, input logic [5:0] sh,
                            input logic [31:0] want);
    alu(op, 32'h8000_0001, b, sh);
    expect_v(tag, O_OUT, want);
    drain();
  endtask

  logic [31:0] ra, rb;
  logic [32:0] wide;

  initial begin
    reset = 1'b1;
    {branch, branchType, brNotEq, carry_we} = '0;
    flag = 2'b00;
    pc = 32'h100;
    imm = 32'hFFFF_FFFE;
    alu(4'b0000, 32'hFFFF_FFFF, 32'd1, 6'd0);
    @(negedge clk);
    expect_v("rst_cq", O_CQ, 0);
    drain();
    reset = 1'b0;

    // ADD carry, carry branch sees old carry_q until the edge
    @(negedge clk);
    carry_we = 1'b1;
    flag = 2'b10;
    branchType = 1'b1;
    expect_v("add_out", O_OUT, 0);
    expect_v("add_cf", O_CF, 1);
    expect_v("add_zf", O_ZF, 1);
    expect_v("add_sf", O_SF, 0);
    expect_v("cbr_old", O_BR, 0);
    drain();
    @(posedge clk);
    expect_v("add_cq", O_CQ, 1);
    expect_v("cbr_new", O_BR, 1);
    drain();
    @(negedge clk);
    carry_we = 1'b0;
    branchType = 1'b0;
    flag = 2'b00;

    alu(4'b1011, 32'd5, 32'd7, 6'd0);
    expect_v("sub_out", O_OUT, 32'hFFFF_FFFE);
    expect_v("sub_cf", O_CF, 0);
    expect_v("sub_sf", O_SF, 1);
    drain();
    alu(4'b1011, 32'd7, 32'd7, 6'd0);
    expect_v("sub_eq_cf", O_CF, 1);
    expect_v("sub_eq_zf", O_ZF, 1);
    drain();
    alu(4'b0001, 32'd3, 32'd0, 6'd0);
    expect_v("comp0_out", O_OUT, 0);
    expect_v("comp0_cf", O_CF, 1);
    drain();
    alu(4'b0001, 32'd3, 32'd5, 6'd0);
    expect_v("comp5_out", O_OUT, 32'hFFFF_FFFB);
    expect_v("comp5_cf", O_CF, 0);
    drain();

    shift_case("shra4", 4'b1000, 32'd0, 6'd4, 32'hF800_0000);
    shift_case("shrl4", 4'b0101, 32'd0, 6'd4, 32'h0800_0000);
    shift_case("shll4", 4'b0100, 32'd0, 6'd4, 32'h0000_0010);
    shift_case("shllv33", 4'b0110, 32'd33, 6'd0, 32'h0);
    shift_case("shllv65", 4'b0110, 32'h41, 6'd0, 32'h2);
    shift_case("shrav40", 4'b1001, 32'd40, 6'd0, 32'hFFFF_FFFF);
    shift_case("shra32", 4'b1000, 32'd0, 6'd32, 32'hFFFF_FFFF);
    shift_case("shrlv0", 4'b0111, 32'd0, 6'd0, 32'h8000_0001);
    shift_case("shrl40", 4'b0101, 32'd0, 6'd40, 32'h0);

    alu(4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'd0);
    expect_v("and_out", O_OUT, 32'h00F0_00F0);
    expect_v("and_cf", O_CF, 0);
    drain();
    alu(4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'd0);
    expect_v("xor_out", O_OUT, 32'hFF00_FF00);
    drain();
    alu(4'b1100, 32'h1234, 32'h5678, 6'd0);
    expect_v("bad_out", O_OUT, 0);
    expect_v("bad_zf", O_ZF, 1);
    drain();

    // Zero-flag branch with PASS x=0
    alu(4'b1010, 32'd0, 32'hFFFF_FFFF, 6'd0);
    branchType = 1'b1;
    expect_v("pc4", O_PC4, 32'h104);
    expect_v("label", O_LBL, 32'hFC);
    expect_v("bz_br", O_BR, 1);
    expect_v("bz_npc", O_NPC, 32'hFC);
    drain();
    brNotEq = 1'b1;
    expect_v("bnz_npc", O_NPC, 32'h104);
    drain();
    brNotEq = 1'b0;
    branchType = 1'b0;
    expect_v("nobr", O_BR, 0);
    drain();

    // Set carry_q, then async reset between edges
    alu(4'b0000, 32'hFFFF_FFFF, 32'd2, 6'd0);
    carry_we = 1'b1;
    @(posedge clk);
    expect_v("cq_set", O_CQ, 1);
    drain();
    @(negedge clk);
    #2 reset = 1'b1;
    expect_v("async_rst", O_CQ, 0);
    drain();
    @(posedge clk);
    expect_v("rst_hold", O_CQ, 0);
    drain();
    @(negedge clk);
    reset = 1'b0;
    carry_we = 1'b0;
    flag = 2'b10;
    branchType = 1'b1;
    expect_v("bc_nt", O_BR, 0);
    expect_v("bc_nt_npc", O_NPC, 32'h104);
    drain();
    brNotEq = 1'b1;
    expect_v("bnc_t", O_BR, 1);
    drain();
    brNotEq = 1'b0;
    branchType = 1'b0;
    branch = 1'b1;
    expect_v("jmp_br", O_BR, 1);
    expect_v("jmp_npc", O_NPC, 32'hFC);
    drain();
    branch = 1'b0;

    // Random ADD/SUB against an independent model
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      if (i[0]) begin
        alu(4'b1011, ra, rb, 6'd0);
        expect_v("rsub_out", O_OUT, ra - rb);
        expect_v("rsub_cf", O_CF, {31'd0, ra >= rb});
      end else begin
        wide = {1'b0, ra} + {1'b0, rb};
        alu(4'b0000, ra, rb, 6'd0);
        expect_v("radd_out", O_OUT, wide[31:0]);
        expect_v("radd_cf", O_CF, {31'd0, wide[32]});
      end
      drain();
    end

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_left got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_branch_unit.md
# exec_branch_unit

Combinational execute datapath of the KGP-RISC single-cycle core, plus one stored-carry register. It bundles the 32-bit ALU, the PC+4 and branch-target adders, and branch resolution. Next-PC selection reduces to a single taken decision. It sits between register-file read and the next-PC mux / data-memory address port.

## Interface
Parameters: none (datapath fixed at 32 bits).

Ports:
- clk  in  1  system clock; only the carry register uses it
- reset  in  1  asynchronous, active-high; clears the carry register
- ALUop  in  4  operation select
- x  in  32  operand A (rs)
- y  in  32  operand B (rt or sign-extended immediate)
- shamt  in  6  immediate shift amount
- pc  in  32  current PC
- imm  in  32  sign-extended branch offset, in words
- flag  in  2  condition select
- branch  in  1  unconditional branch/link
- branchType  in  1  conditional branch enable
- brNotEq  in  1  invert condition
- carry_we  in  1  update stored carry this cycle
- out  out  32  ALU result
- carryflag, zflag, signflag  out  1 each  combinational flags of current op
- carry_q  out  1  stored carry
- pc_plus_4, label_address, next_pc  out  32 each
- brType  out  1  branch taken

## Operation
ALUop encoding (mod 2^32):
- 0000 ADD: x+y
- 0001 COMP: ~y+1
- 0010 AND: x&y
- 0011 XOR: x^y
- 0100 SHLL: x<<shamt
- 0101 SHRL: x>>shamt
- 0110 SHLLV: x<<y[5:0]
- 0111 SHRLV: x>>y[5:0]
- 1000 SHRA: x>>>shamt
- 1001 SHRAV: x>>>y[5:0]
- 1010 PASS: x
- 1011 SUB: x+~y+1
- other codes: out=0

Shift rules:
- Amount ≥32: logical shifts give 0; arithmetic shifts give 32 copies of x[31].
- Amount 0: out=x.

Flags:
- carryflag = bit-32 carry of the 33-bit sum for ADD, COMP, SUB; 0 for every other op. COMP carry=1 iff y==0; SUB carry=1 iff x≥y unsigned.
- zflag = (out==0).
- signflag = out[31].

Adders:
- pc_plus_4 = pc+4.
- label_address = pc_plus_4 + (imm<<2); wraps, no overflow detect.

Branch:
- cond by flag: 00 zflag, 01 signflag, 10 carry_q, 11 constant 1.
- brType = branch | (branchType & (cond ^ brNotEq)).
- next_pc = brType ? label_address : pc_plus_4.
- branch=1 forces taken regardless of the other branch inputs.
- branchType=0 and branch=0 → not taken.

## Timing
- All outputs except carry_q are purely combinational; zero latency from inputs.
- carry_q: rising clk with carry_we=1 loads carryflag; with carry_we=0 it holds.
- Reset:
  - reset high → carry_q=0 immediately, independent of clk.
  - While reset is high, carry_q stays 0 even if carry_we=1.
  - Deasserting reset mid-cycle has no effect until the next rising edge.
- A carry branch (flag=10) uses the carry stored by an earlier instruction, never the same-cycle carryflag.
- Simultaneous carry_we=1 and flag=10: the branch uses the old carry_q; the new value is visible after the edge.

## Test plan
- ADD x=0xFFFFFFFF, y=1 → out=0, carryflag=1, zflag=1, signflag=0; with carry_we=1, after the edge carry_q=1.
- SUB x=5, y=7 → out=0xFFFFFFFE, carryflag=0, signflag=1. COMP y=0 → out=0, carryflag=1.
- Shifts, x=0x80000001:
  - SHRA shamt=4 → 0xF8000000
  - SHRL shamt=4 → 0x08000000
  - SHLLV y=33 → 0
  - SHRAV y=40 → 0xFFFFFFFF
- pc=0x100, imm=-2 → pc_plus_4=0x104, label_address=0xFC. flag=00, branchType=1, PASS x=0 → brType=1, next_pc=0xFC. Same with brNotEq=1 → next_pc=0x104.
- Carry-register path:
  - Set carry_q=1; assert reset asynchronously between edges → carry_q=0 at once.
  - Then flag=10, branchType=1 → not taken.
  - With brNotEq=1 → taken.
- branch=1, branchType=0, flag=10, carry_q=0 → brType=1. AND 0xF0F0F0F0 & 0x0FF00FF0 → 0x00F000F0, carryflag=0.
